cpu_controller: RTL

//  Moore control unit that sequences the 16x16 register file, ALU, data memory and instruction ROM.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/cpu_controller_if.sv | 32 +++
 rtl/cpu_controller_pc_ir_reg.sv | 28 ++
 rtl/cpu_controller.sv | 97 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU control unit: opcodes, FSM states, ALU op codes.
package cpu_pkg;

  localparam int PC_W    = 7;
  localparam int DADDR_W = 8;
  localparam int RA_W    = 4;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_e;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/cpu_controller_if.sv
// Bundle of control-unit signals toward ROM, register file, ALU and data memory.
interface cpu_controller_if #(
  parameter int PC_W    = 7,
  parameter int DADDR_W = 8,
  parameter int RA_W    = 4
);
  logic [15:0]        Instr;
  logic [PC_W-1:0]    PcAddr;
  logic [15:0]        IrOut;
  logic [DADDR_W-1:0] DAddr;
  logic               DWrite;
  logic               RfSel;
  logic [RA_W-1:0]    RfWAddr;
  logic               RfWrite;
  logic [RA_W-1:0]    RfRAddrA;
  logic [RA_W-1:0]    RfRAddrB;
  logic [2:0]         AluSel;
  logic               Halted;
  logic [3:0]         StateOut;

  modport master (
    input  Instr,
    output PcAddr, IrOut, DAddr, DWrite, RfSel, RfWAddr, RfWrite,
           RfRAddrA, RfRAddrB, AluSel, Halted, StateOut
  );

  modport slave (
    output Instr,
    input  PcAddr, IrOut, DAddr, DWrite, RfSel, RfWAddr, RfWrite,
           RfRAddrA, RfRAddrB, AluSel, Halted, StateOut
  );
endinterface

// File: rtl/cpu_controller_pc_ir_reg.sv
// Program counter and instruction register; a load captures the ROM word and advances PC.
module pc_ir_reg #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [15:0]     instr,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ir
);
  logic [PC_W-1:0] pc_reg;
  logic [15:0]     ir_reg;

  // PC is exactly PC_W bits wide, so the increment wraps to 0 on its own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= '0;
      ir_reg <= '0;
    end else if (load) begin
      pc_reg <= pc_reg + 1'b1;
      ir_reg <= instr;
    end
  end

  assign pc = pc_reg;
  assign ir = ir_reg;
endmodule

// File: rtl/cpu_controller.sv
// Moore control unit: fetch/decode/execute sequencer driving RF, ALU and data-memory controls.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    ResetN,
  cpu_controller_if.master        bus
);
  state_e          state_reg;
  state_e          state_next;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;

  pc_ir_reg #(.PC_W(PC_W)) u_pc_ir (
    .clk   (clk),
    .rst_n (ResetN),
    .load  (state_reg == S_FETCH),
    .instr (bus.Instr),
    .pc    (pc),
    .ir    (ir)
  );

  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) state_reg <= S_INIT;
    else         state_reg <= state_next;
  end

  // Undefined opcodes behave like NOOP and return straight to FETCH
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_INIT:   state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (ir[15:12])
          OP_STORE: state_next = S_STORE;
          OP_LOAD:  state_next = S_LOAD_A;
          OP_ADD:   state_next = S_ADD;
          OP_SUB:   state_next = S_SUB;
          OP_HALT:  state_next = S_HALT;
          default:  state_next = S_FETCH;
        endcase
      end
      S_LOAD_A: state_next = S_LOAD_B;
      S_LOAD_B: state_next = S_FETCH;
      S_STORE:  state_next = S_FETCH;
      S_ADD:    state_next = S_FETCH;
      S_SUB:    state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // Outputs decode only state and IR, so reset clears every enable immediately
  always_comb begin
    bus.DAddr    = '0;
    bus.DWrite   = 1'b0;
    bus.RfSel    = 1'b0;
    bus.RfWAddr  = '0;
    bus.RfWrite  = 1'b0;
    bus.RfRAddrA = '0;
    bus.RfRAddrB = '0;
    bus.AluSel   = ALU_PASS;
    bus.Halted   = 1'b0;
    case (state_reg)
      S_STORE: begin
        bus.DAddr    = ir[7:0];
        bus.RfRAddrA = ir[11:8];
        bus.DWrite   = 1'b1;
      end
      S_LOAD_A: begin
        bus.DAddr = ir[7:0];
      end
      S_LOAD_B: begin
        bus.DAddr   = ir[7:0];
        bus.RfSel   = 1'b1;
        bus.RfWAddr = ir[11:8];
        bus.RfWrite = 1'b1;
      end
      S_ADD, S_SUB: begin
        bus.RfRAddrA = ir[11:8];
        bus.RfRAddrB = ir[7:4];
        bus.RfWAddr  = ir[3:0];
        bus.RfWrite  = 1'b1;
        bus.AluSel   = (state_reg == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      S_HALT: begin
        bus.Halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PcAddr   = pc;
  assign bus.IrOut    = ir;
  assign bus.StateOut = state_reg;
endmodule
